multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore-style main FSM plus ALU-control decode that sequences the team's multicycle MIPS datapath.
- Consumes opc/func from IR and the ALU zero flag; drives every datapath control input (PCWrite … PCSrc).
- The branch condition is folded into a single gated PCWrite.
- Adds an instr_done pulse for verification and performance counting.

Parameters:
- ENABLE_BNE, 1: 1 = decode bne (opc 000101); 0 = bne treated as unknown opcode.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opc  in  6  IR[31:26]
- func  in  6  IR[5:0]
- zero  in  1  ALU zero flag (combinational, current cycle)
- PCWrite  out  1  PC load (already gated by branch condition)
- IorD  out  1  0 = PC, 1 = ALUOut as memory address
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR load
- RegDst  out  1  0 = rt, 1 = rd
- JalSig1  out  1  1 = write register 31
- MemToReg  out  1  0 = MDR, 1 = ALUOut
- JalSig2  out  1  1 = write-data is PC
- RegWrite  out  1  register-file write
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  0 = B, 1 = const 4, 2 = SE, 3 = SE<<2
- ALUOperation  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- PCSrc  out  2  0 = ALU res, 1 = jump addr, 2 = ALUOut, 3 = A
- instr_done  out  1  one-cycle pulse in an instruction's final state

Behaviour:
- Reset:
  - state <= FETCH asynchronously.
  - While rst = 1, all outputs are forced to 0, including strobes and instr_done.
  - First FETCH occurs on the first clk after rst deasserts.
  - Reset mid-instruction aborts it; no write strobe is asserted after rst rises.
- Outputs are decoded combinationally from state, with zero used only in BRANCH; unlisted signals are 0.
- FETCH: MemRead, IRWrite, IorD=0, ALUSrcA=0, ALUSrcB=1, add, PCSrc=0, PCWrite=1 -> DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=3, add (branch target into ALUOut); next state by opc:
  - lw / sw -> MEM_ADR
  - R-type -> R_EX, or JR if func = 001000
  - addi / slti / andi -> I_EX
  - beq / bne -> BRANCH
  - j -> JUMP
  - jal -> JAL
  - anything else -> FETCH with instr_done = 1 (NOP)
- MEM_ADR: ALUSrcA=1, ALUSrcB=2, add -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: MemRead, IorD=1 -> MEM_WB.
- MEM_WB: RegWrite, RegDst=0, MemToReg=0, instr_done -> FETCH.
- MEM_WR: MemWrite, IorD=1, instr_done -> FETCH.
- R_EX: ALUSrcA=1, ALUSrcB=0, ALUOperation from func -> R_WB.
  - Func map: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Unknown func -> add; the write still occurs.
- R_WB: RegWrite, RegDst=1, MemToReg=1, instr_done -> FETCH.
- I_EX: ALUSrcA=1, ALUSrcB=2; addi add, slti slt, andi and -> I_WB.
- I_WB: RegWrite, RegDst=0, MemToReg=1, instr_done -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, sub, PCSrc=2, instr_done -> FETCH.
  - PCWrite = zero for beq, ~zero for bne.
- JUMP: PCSrc=1, PCWrite, instr_done -> FETCH.
- JAL: PCSrc=1, PCWrite, RegWrite, JalSig1, JalSig2, instr_done -> FETCH.
  - PC already holds PC+4 from FETCH, so $31 receives PC+4.
- JR: PCSrc=3, PCWrite, instr_done -> FETCH.
- Latency in cycles, FETCH included:
  - lw 5
  - sw, R-type, I-type 4
  - beq/bne, j, jal, jr 3
  - unknown opcode 2
- Unreachable state encodings -> FETCH with all outputs 0.

Decomposition:
- Shared package mips_defs:
  - opcode constants: RTYPE, LW, SW, BEQ, BNE, ADDI, SLTI, ANDI, J, JAL
  - funct constants: ADD, SUB, AND, OR, SLT, JR
  - ALUOperation codes
  - state enum, 4-bit
- One natural sub-module: alu_op_decoder.
  - Combinational; maps (state class, opc, func) to ALUOperation.
  - Reused later by a pipelined core.

Test Plan:
- rst=1 for 3 cycles, then release -> all outputs 0 during reset; cycle 1 after release shows MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- lw (opc 100011) -> states FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB; RegWrite only in cycle 5; instr_done pulses once.
- R-type sub (func 100010) -> ALUOperation=110 in R_EX; R_WB has RegDst=1, MemToReg=1; 4 cycles.
- beq with zero=1, then beq with zero=0 -> PCWrite=1/PCSrc=10, then PCWrite=0 in BRANCH; repeat for bne, expecting the inverse.
- jal then jr -> JAL cycle has JalSig1=1, JalSig2=1, RegWrite=1, PCSrc=01; JR cycle has PCSrc=11, PCWrite=1.
- sw, then opc 111111, then rst pulsed during MEM_ADR -> sw: MemWrite=1/IorD=1 in cycle 4; unknown opcode: back to FETCH after DECODE; reset pulse: FETCH with no MemWrite.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared MIPS definitions: opcode/funct encodings, ALU operation codes,
// controller state encoding and the per-state control bundle.
package mips_defs;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALUOP_AND = 3'b000;
  localparam logic [2:0] ALUOP_OR  = 3'b001;
  localparam logic [2:0] ALUOP_ADD = 3'b010;
  localparam logic [2:0] ALUOP_SUB = 3'b110;
  localparam logic [2:0] ALUOP_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_R_EX,
    S_R_WB, S_I_EX, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR
  } state_e;

  // What the ALU is being used for in a given state; AC_NONE yields 000.
  typedef enum logic [2:0] {
    AC_NONE, AC_ADD, AC_SUB, AC_FUNC, AC_IMM
  } alu_class_e;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       jal_sig1;
    logic       mem_to_reg;
    logic       jal_sig2;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       instr_done;
    alu_class_e alu_class;
  } ctrl_t;

endpackage

// File: rtl/alu_op_decoder.sv
// ALU control decode: turns the state's ALU usage class plus opc/func into
// the 3-bit ALUOperation code. Purely combinational.
module alu_op_decoder
  import mips_defs::*;
(
  input  alu_class_e alu_class_i,
  input  logic [5:0] opc_i,
  input  logic [5:0] func_i,
  output logic [2:0] alu_op_o
);

  always_comb begin
    alu_op_o = ALUOP_AND;
    case (alu_class_i)
      AC_ADD: alu_op_o = ALUOP_ADD;
      AC_SUB: alu_op_o = ALUOP_SUB;
      AC_FUNC: begin
        // Unrecognised funct falls back to add; the register write still happens.
        case (func_i)
          FN_SUB:  alu_op_o = ALUOP_SUB;
          FN_AND:  alu_op_o = ALUOP_AND;
          FN_OR:   alu_op_o = ALUOP_OR;
          FN_SLT:  alu_op_o = ALUOP_SLT;
          default: alu_op_o = ALUOP_ADD;
        endcase
      end
      AC_IMM: begin
        case (opc_i)
          OPC_SLTI: alu_op_o = ALUOP_SLT;
          OPC_ANDI: alu_op_o = ALUOP_AND;
          default:  alu_op_o = ALUOP_ADD;
        endcase
      end
      default: alu_op_o = ALUOP_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore main FSM for the multicycle MIPS datapath. Branch condition is folded
// into PCWrite; instr_done marks each instruction's final cycle.
module multicycle_controller
  import mips_defs::*;
#(
  parameter bit ENABLE_BNE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opc,
  input  logic [5:0] func,
  input  logic       zero,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       JalSig1,
  output logic       MemToReg,
  output logic       JalSig2,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOperation,
  output logic [1:0] PCSrc,
  output logic       instr_done
);

  state_e state_q, state_d;
  ctrl_t  ctrl_d, ctrl_o;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ctrl_d  = '0;
    case (state_q)
      S_FETCH: begin
        ctrl_d.mem_read  = 1'b1;
        ctrl_d.ir_write  = 1'b1;
        ctrl_d.alu_src_b = 2'd1;
        ctrl_d.alu_class = AC_ADD;
        ctrl_d.pc_write  = 1'b1;
        state_d          = S_DECODE;
      end
      S_DECODE: begin
        ctrl_d.alu_src_b = 2'd3;
        ctrl_d.alu_class = AC_ADD;
        case (opc)
          OPC_LW, OPC_SW:               state_d = S_MEM_ADR;
          OPC_RTYPE:                    state_d = (func == FN_JR) ? S_JR : S_R_EX;
          OPC_ADDI, OPC_SLTI, OPC_ANDI: state_d = S_I_EX;
          OPC_BEQ:                      state_d = S_BRANCH;
          OPC_J:                        state_d = S_JUMP;
          OPC_JAL:                      state_d = S_JAL;
          OPC_BNE: begin
            state_d           = ENABLE_BNE ? S_BRANCH : S_FETCH;
            ctrl_d.instr_done = !ENABLE_BNE;
          end
          default: begin
            state_d           = S_FETCH;
            ctrl_d.instr_done = 1'b1;
          end
        endcase
      end
      S_MEM_ADR: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = 2'd2;
        ctrl_d.alu_class = AC_ADD;
        state_d          = (opc == OPC_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        ctrl_d.mem_read = 1'b1;
        ctrl_d.iord     = 1'b1;
        state_d         = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.instr_done = 1'b1;
        state_d           = S_FETCH;
      end
      S_MEM_WR: begin
        ctrl_d.mem_write  = 1'b1;
        ctrl_d.iord       = 1'b1;
        ctrl_d.instr_done = 1'b1;
        state_d           = S_FETCH;
      end
      S_R_EX: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_class = AC_FUNC;
        state_d          = S_R_WB;
      end
      S_R_WB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.reg_dst    = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.instr_done = 1'b1;
        state_d           = S_FETCH;
      end
      S_I_EX: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = 2'd2;
        ctrl_d.alu_class = AC_IMM;
        state_d          = S_I_WB;
      end
      S_I_WB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.instr_done = 1'b1;
        state_d           = S_FETCH;
      end
      S_BRANCH: begin
        ctrl_d.alu_src_a  = 1'b1;
        ctrl_d.alu_class  = AC_SUB;
        ctrl_d.pc_src     = 2'd2;
        ctrl_d.pc_write   = (opc == OPC_BNE) ? !zero : zero;
        ctrl_d.instr_done = 1'b1;
        state_d           = S_FETCH;
      end
      S_JUMP, S_JAL: begin
        ctrl_d.pc_src     = 2'd1;
        ctrl_d.pc_write   = 1'b1;
        ctrl_d.reg_write  = (state_q == S_JAL);
        ctrl_d.jal_sig1   = (state_q == S_JAL);
        ctrl_d.jal_sig2   = (state_q == S_JAL);
        ctrl_d.instr_done = 1'b1;
        state_d           = S_FETCH;
      end
      S_JR: begin
        ctrl_d.pc_src     = 2'd3;
        ctrl_d.pc_write   = 1'b1;
        ctrl_d.instr_done = 1'b1;
        state_d           = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs are held at zero while rst is high so no strobe leaks mid-abort.
  assign ctrl_o = rst ? '0 : ctrl_d;

  alu_op_decoder u_alu_op_decoder (
    .alu_class_i (ctrl_o.alu_class),
    .opc_i       (opc),
    .func_i      (func),
    .alu_op_o    (ALUOperation)
  );

  assign PCWrite    = ctrl_o.pc_write;
  assign IorD       = ctrl_o.iord;
  assign MemRead    = ctrl_o.mem_read;
  assign MemWrite   = ctrl_o.mem_write;
  assign IRWrite    = ctrl_o.ir_write;
  assign RegDst     = ctrl_o.reg_dst;
  assign JalSig1    = ctrl_o.jal_sig1;
  assign MemToReg   = ctrl_o.mem_to_reg;
  assign JalSig2    = ctrl_o.jal_sig2;
  assign RegWrite   = ctrl_o.reg_write;
  assign ALUSrcA    = ctrl_o.alu_src_a;
  assign ALUSrcB    = ctrl_o.alu_src_b;
  assign PCSrc      = ctrl_o.pc_src;
  assign instr_done = ctrl_o.instr_done;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each instruction's expected
// per-cycle control trace is queued, and a negedge monitor compares it.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pcw, iord, mrd, mwr, irw, rdst, jal1, m2r, jal2, rw, srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic       done;
  } cv_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opc = '0;
  logic [5:0] func = '0;
  logic       zero = 1'b0;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, JalSig1;
  logic       MemToReg, JalSig2, RegWrite, ALUSrcA, instr_done;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUOperation;

  multicycle_controller #(.ENABLE_BNE(1'b1)) dut (
    .clk(clk), .rst(rst), .opc(opc), .func(func), .zero(zero),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .JalSig1(JalSig1), .MemToReg(MemToReg),
    .JalSig2(JalSig2), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOperation(ALUOperation), .PCSrc(PCSrc), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  bit    mon_en = 1'b0;
  cv_t   exp_q[$];
  string name_q[$];
  cv_t   trace[$];
  int    instr_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents a control vector, pop and compare.
  always @(negedge clk) begin
    if (mon_en) begin
      cv_t act;
      act = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, JalSig1, MemToReg,
             JalSig2, RegWrite, ALUSrcA, ALUSrcB, ALUOperation, PCSrc, instr_done};
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_cycle actual=%h required=none", act);
      end else begin
        cv_t   e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, 32'(act), 32'(e));
      end
    end
  end

  // Reference model: the instruction's control trace, cycle by cycle.
  function automatic logic [2:0] r_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  task automatic build_trace(input logic [5:0] o, input logic [5:0] f, input logic z);
    cv_t c;
    trace.delete();
    c = '0; c.mrd = 1; c.irw = 1; c.srcb = 2'd1; c.aluop = 3'b010; c.pcw = 1;
    trace.push_back(c);
    c = '0; c.srcb = 2'd3; c.aluop = 3'b010;
    case (o)
      6'b100011, 6'b101011: begin
        trace.push_back(c);
        c = '0; c.srca = 1; c.srcb = 2'd2; c.aluop = 3'b010; trace.push_back(c);
        if (o == 6'b100011) begin
          c = '0; c.mrd = 1; c.iord = 1; trace.push_back(c);
          c = '0; c.rw = 1; c.done = 1; trace.push_back(c);
        end else begin
          c = '0; c.mwr = 1; c.iord = 1; c.done = 1; trace.push_back(c);
        end
      end
      6'b000000: begin
        trace.push_back(c);
        if (f == 6'b001000) begin
          c = '0; c.pcsrc = 2'd3; c.pcw = 1; c.done = 1; trace.push_back(c);
        end else begin
          c = '0; c.srca = 1; c.aluop = r_alu(f); trace.push_back(c);
          c = '0; c.rw = 1; c.rdst = 1; c.m2r = 1; c.done = 1; trace.push_back(c);
        end
      end
      6'b001000, 6'b001010, 6'b001100: begin
        trace.push_back(c);
        c = '0; c.srca = 1; c.srcb = 2'd2;
        c.aluop = (o == 6'b001010) ? 3'b111 : (o == 6'b001100) ? 3'b000 : 3'b010;
        trace.push_back(c);
        c = '0; c.rw = 1; c.m2r = 1; c.done = 1; trace.push_back(c);
      end
      6'b000100, 6'b000101: begin
        trace.push_back(c);
        c = '0; c.srca = 1; c.aluop = 3'b110; c.pcsrc = 2'd2; c.done = 1;
        c.pcw = (o == 6'b000100) ? z : !z;
        trace.push_back(c);
      end
      6'b000010, 6'b000011: begin
        trace.push_back(c);
        c = '0; c.pcsrc = 2'd1; c.pcw = 1; c.done = 1;
        if (o == 6'b000011) begin c.rw = 1; c.jal1 = 1; c.jal2 = 1; end
        trace.push_back(c);
      end
      default: begin
        c.done = 1;
        trace.push_back(c);
      end
    endcase
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input cv_t c, input string n);
    exp_q.push_back(c);
    name_q.push_back(n);
  endtask

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      rst = 1'b1;
      push_exp('0, $sformatf("reset_cyc%0d", i));
    end
  endtask

  // abort_after = 0 runs the whole instruction; otherwise reset after that many cycles.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int abort_after);
    int n;
    next_cycle();
    rst = 1'b0; opc = o; func = f; zero = z;
    build_trace(o, f, z);
    n = (abort_after > 0 && abort_after < trace.size()) ? abort_after : trace.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) next_cycle();
      push_exp(trace[i], $sformatf("i%0d_opc%b_fn%b_cyc%0d", instr_idx, o, f, i + 1));
    end
    instr_idx++;
    if (n < trace.size()) hold_reset(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] opcs[10];
    logic [5:0] fns[8];
    opcs = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
             6'b001000, 6'b001010, 6'b001100, 6'b000010, 6'b000011};
    fns  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
             6'b001000, 6'b111111, 6'b000000};
    mon_en = 1'b1;
    hold_reset(3);
    // Directed sequence from the test plan.
    run_instr(6'b100011, 6'b000000, 1'b0, 0);  // lw
    run_instr(6'b000000, 6'b100010, 1'b0, 0);  // sub
    run_instr(6'b000100, 6'b000000, 1'b1, 0);  // beq taken
    run_instr(6'b000100, 6'b000000, 1'b0, 0);  // beq not taken
    run_instr(6'b000101, 6'b000000, 1'b1, 0);  // bne not taken
    run_instr(6'b000101, 6'b000000, 1'b0, 0);  // bne taken
    run_instr(6'b000011, 6'b000000, 1'b0, 0);  // jal
    run_instr(6'b000000, 6'b001000, 1'b0, 0);  // jr
    run_instr(6'b101011, 6'b000000, 1'b0, 0);  // sw
    run_instr(6'b111111, 6'b000000, 1'b0, 0);  // unknown opcode
    run_instr(6'b101011, 6'b000000, 1'b0, 2);  // sw reset during MEM_ADR
    run_instr(6'b000000, 6'b110011, 1'b0, 0);  // unknown funct -> add
    // Randomised instruction stream with occasional aborts.
    for (int k = 0; k < 200; k++) begin
      logic [5:0] o, f;
      int ab;
      o  = ($urandom_range(9, 0) < 8) ? opcs[$urandom_range(9, 0)] : 6'($urandom);
      f  = ($urandom_range(3, 0) != 0) ? fns[$urandom_range(7, 0)] : 6'($urandom);
      ab = ($urandom_range(19, 0) == 0) ? int'($urandom_range(4, 1)) : 0;
      run_instr(o, f, 1'($urandom), ab);
    end
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
